// File: rtl/bclk_eye_trainer.sv
// Receive-clock eye trainer: sweeps an IOD delay line tap by tap, finds the first clean eye,
// and parks the delay line at the centre of that eye.
// Ports:
//   i_fab_clk, i_arst                fabric clock, async active-high reset
//   i_start                          one-cycle training request (ignored while busy)
//   i_eye_monitor_early_0/late_0     sticky eye-monitor flags from the IOD
//   i_delay_line_out_of_range_0      delay line has reached its limit
//   o_delay_line_load_0/move_0       one-cycle delay-line control pulses
//   o_delay_line_direction_0         1 = increment, 0 = decrement (valid with move)
//   o_eye_monitor_clear_flags_0      one-cycle pulse clearing the sticky flags
//   o_busy, o_done, o_fail           status; done/fail hold until the next start
//   o_center_tap, o_eye_width        training result
module bclk_eye_trainer #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLES       = 16,
  parameter int unsigned MAX_TAPS      = 128,
  parameter int unsigned MIN_EYE       = 4
) (
  input  logic       i_fab_clk,
  input  logic       i_arst,
  input  logic       i_start,
  input  logic       i_eye_monitor_early_0,
  input  logic       i_eye_monitor_late_0,
  input  logic       i_delay_line_out_of_range_0,
  output logic       o_delay_line_load_0,
  output logic       o_delay_line_move_0,
  output logic       o_delay_line_direction_0,
  output logic       o_eye_monitor_clear_flags_0,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [7:0] o_center_tap,
  output logic [7:0] o_eye_width
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
    S_STEP, S_BACK, S_BSETTLE, S_DONE, S_FAIL
  } state_t;

  localparam logic [7:0] SET_LD   = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SMP_LD   = 8'(SAMPLES - 1);
  localparam logic [7:0] LAST_TAP = 8'(MAX_TAPS - 1);
  localparam logic [8:0] MIN_W    = 9'(MIN_EYE);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_tap;
  logic [7:0] r_es;
  logic [7:0] r_ee;
  logic       r_sv;
  logic       r_dirty;
  logic       r_oor;
  logic       r_end;
  logic [7:0] r_center;
  logic       r_load;
  logic       r_move;
  logic       r_dir;
  logic       r_clear;
  logic       r_busy;
  logic       r_done;
  logic       r_fail;
  logic [7:0] r_center_tap;
  logic [7:0] r_eye_width;

  logic       w_dirty;
  logic       w_oor;
  logic       w_bad;
  logic       w_end;
  logic [8:0] w_width;
  logic [8:0] w_sum;
  logic [7:0] w_center;

  // Window accumulation includes the current cycle so the sweep decision
  // is ready on the last sample and the move pulse lands in STEP itself.
  always_comb begin
    w_dirty  = r_dirty | i_eye_monitor_early_0 | i_eye_monitor_late_0;
    w_oor    = r_oor | i_delay_line_out_of_range_0;
    w_bad    = w_dirty | w_oor;
    w_end    = (w_bad & r_sv) | (r_tap == LAST_TAP) | w_oor;
    w_width  = {1'b0, r_ee} - {1'b0, r_es} + 9'd1;
    w_sum    = {1'b0, r_es} + {1'b0, r_ee};
    w_center = 8'(w_sum >> 1);
  end

  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tap        <= '0;
      r_es         <= '0;
      r_ee         <= '0;
      r_sv         <= 1'b0;
      r_dirty      <= 1'b0;
      r_oor        <= 1'b0;
      r_end        <= 1'b0;
      r_center     <= '0;
      r_load       <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
      r_clear      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_center_tap <= '0;
      r_eye_width  <= '0;
    end else begin
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_clear <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            r_load       <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_tap        <= '0;
            r_sv         <= 1'b0;
            r_center_tap <= '0;
            r_eye_width  <= '0;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_clear <= 1'b1;
          r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_cnt   <= SET_LD;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_cnt   <= SMP_LD;
            r_dirty <= 1'b0;
            r_oor   <= 1'b0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          r_dirty <= w_dirty;
          r_oor   <= w_oor;
          if (r_cnt == 8'd0) begin
            // An out-of-range tap is treated as dirty.
            if (!w_bad) begin
              if (!r_sv) begin
                r_es <= r_tap;
                r_sv <= 1'b1;
              end
              r_ee <= r_tap;
            end
            r_end   <= w_end;
            r_move  <= ~w_end;
            r_dir   <= 1'b1;
            r_state <= S_STEP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STEP: begin
          if (!r_end) begin
            r_tap   <= r_tap + 8'd1;
            r_clear <= 1'b1;
            r_state <= S_CLEAR;
          end else if (!r_sv || (w_width < MIN_W)) begin
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_eye_width <= r_sv ? w_width[7:0] : 8'd0;
            r_state     <= S_FAIL;
          end else begin
            r_center    <= w_center;
            r_eye_width <= w_width[7:0];
            r_state     <= S_BACK;
          end
        end
        S_BACK: begin
          if (r_tap > r_center) begin
            r_move  <= 1'b1;
            r_dir   <= 1'b0;
            r_tap   <= r_tap - 8'd1;
            r_cnt   <= SET_LD;
            r_state <= S_BSETTLE;
          end else begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_center_tap <= r_center;
            r_state      <= S_DONE;
          end
        end
        S_BSETTLE: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_BACK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_delay_line_load_0         = r_load;
  assign o_delay_line_move_0         = r_move;
  assign o_delay_line_direction_0    = r_dir;
  assign o_eye_monitor_clear_flags_0 = r_clear;
  assign o_busy                      = r_busy;
  assign o_done                      = r_done;
  assign o_fail                      = r_fail;
  assign o_center_tap                = r_center_tap;
  assign o_eye_width                 = r_eye_width;

endmodule

// File: tb/tb_bclk_eye_trainer.sv
// Testbench for bclk_eye_trainer: emulated IOD delay line and eye monitor,
// table vectors, random eyes against a sweep model, reset and restart corners.
module tb_bclk_eye_trainer;

  typedef struct {
    int done;
    int fail;
    int center;
    int width;
    int ups;
    int downs;
  } exp_t;

  typedef struct {
    logic [15:0] dirty;
    int          oor;
    exp_t        e4;
    exp_t        e3;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dirty_map = '0;
  logic [7:0]  tap_env = '0;
  int          oor_tap = -1;
  logic        early, late, oor;

  logic       load, move, dir, clr, busy, done, fail;
  logic [7:0] ctap, ewid;
  logic       load3, move3, dir3, clr3, busy3, done3, fail3;
  logic [7:0] ctap3, ewid3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0, last_t = 0;
  int loads = 0, ups = 0, downs = 0, ups3 = 0, downs3 = 0;
  int per_err = 0, excl_err = 0;

  assign early = dirty_map[tap_env[3:0]] & tap_env[0];
  assign late  = dirty_map[tap_env[3:0]] & ~tap_env[0];
  assign oor   = (int'(tap_env) == oor_tap);

  always #5 clk = ~clk;

  bclk_eye_trainer #(
    .SETTLE_CYCLES(2), .SAMPLES(4), .MAX_TAPS(16), .MIN_EYE(4)
  ) dut (
    .i_fab_clk(clk), .i_arst(arst), .i_start(start),
    .i_eye_monitor_early_0(early), .i_eye_monitor_late_0(late),
    .i_delay_line_out_of_range_0(oor),
    .o_delay_line_load_0(load), .o_delay_line_move_0(move),
    .o_delay_line_direction_0(dir), .o_eye_monitor_clear_flags_0(clr),
    .o_busy(busy), .o_done(done), .o_fail(fail),
    .o_center_tap(ctap), .o_eye_width(ewid)
  );

  bclk_eye_trainer #(
    .SETTLE_CYCLES(2), .SAMPLES(4), .MAX_TAPS(16), .MIN_EYE(3)
  ) dut3 (
    .i_fab_clk(clk), .i_arst(arst), .i_start(start),
    .i_eye_monitor_early_0(early), .i_eye_monitor_late_0(late),
    .i_delay_line_out_of_range_0(oor),
    .o_delay_line_load_0(load3), .o_delay_line_move_0(move3),
    .o_delay_line_direction_0(dir3), .o_eye_monitor_clear_flags_0(clr3),
    .o_busy(busy3), .o_done(done3), .o_fail(fail3),
    .o_center_tap(ctap3), .o_eye_width(ewid3)
  );

  // Delay-line emulation and pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (int'(load) + int'(move) + int'(clr) > 1) excl_err = excl_err + 1;
    if (int'(load3) + int'(move3) + int'(clr3) > 1) excl_err = excl_err + 1;
    if (load) begin
      loads = loads + 1;
      tap_env = 8'd0;
      last_t = cyc;
    end
    if (move) begin
      if (dir) begin
        ups = ups + 1;
        if (cyc - last_t != 8) per_err = per_err + 1;
        last_t = cyc;
        tap_env = tap_env + 8'd1;
      end else begin
        downs = downs + 1;
        tap_env = tap_env - 8'd1;
      end
    end
    if (move3) begin
      if (dir3) ups3 = ups3 + 1;
      else downs3 = downs3 + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sweep model: walk taps upward, keep the first contiguous clean run,
  // stop on the first dirty tap after it, the last tap, or out-of-range.
  function automatic exp_t model(logic [15:0] d, int oor_t, int me);
    exp_t r;
    int s = -1;
    int e = -1;
    int stop = 15;
    int w;
    for (int t = 0; t < 16; t++) begin
      bit bad;
      bad = d[t] || (t == oor_t);
      if (!bad) begin
        if (s < 0) s = t;
        e = t;
      end
      if ((bad && s >= 0) || t == 15 || t == oor_t) begin
        stop = t;
        break;
      end
    end
    w = (s >= 0) ? e - s + 1 : 0;
    r.ups = stop;
    r.width = w;
    if (s >= 0 && w >= me) begin
      r.done = 1;
      r.fail = 0;
      r.center = (s + e) / 2;
      r.downs = stop - r.center;
    end else begin
      r.done = 0;
      r.fail = 1;
      r.center = 0;
      r.downs = 0;
    end
    return r;
  endfunction

  task automatic run(input vec_t v, input bit poke, input string tag);
    int k;
    bit fin;
    @(negedge clk);
    dirty_map = v.dirty;
    oor_tap = v.oor;
    loads = 0; ups = 0; downs = 0; ups3 = 0; downs3 = 0;
    per_err = 0; excl_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, int'(busy & busy3), 1);
    fin = 1'b0;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      start = poke && (k == 20 || k == 50);
      if (!busy && !busy3 && (done | fail) && (done3 | fail3)) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " finish"}, int'(fin), 1);
    repeat (3) @(negedge clk);
    chk({tag, " done"}, int'(done), v.e4.done);
    chk({tag, " fail"}, int'(fail), v.e4.fail);
    chk({tag, " center"}, int'(ctap), v.e4.center);
    chk({tag, " width"}, int'(ewid), v.e4.width);
    chk({tag, " ups"}, ups, v.e4.ups);
    chk({tag, " downs"}, downs, v.e4.downs);
    chk({tag, " tap"}, int'(tap_env),
        v.e4.done ? v.e4.center : v.e4.ups);
    chk({tag, " loads"}, loads, 1);
    chk({tag, " period"}, per_err, 0);
    chk({tag, " exclusive"}, excl_err, 0);
    chk({tag, " m3 done"}, int'(done3), v.e3.done);
    chk({tag, " m3 fail"}, int'(fail3), v.e3.fail);
    chk({tag, " m3 center"}, int'(ctap3), v.e3.center);
    chk({tag, " m3 width"}, int'(ewid3), v.e3.width);
    chk({tag, " m3 ups"}, ups3, v.e3.ups);
    chk({tag, " m3 downs"}, downs3, v.e3.downs);
  endtask

  function automatic int outs_or();
    return int'({load, move, dir, clr, busy, done, fail, ctap, ewid,
                 load3, move3, dir3, clr3, busy3, done3, fail3,
                 ctap3, ewid3} != '0);
  endfunction

  vec_t tbl[8];
  vec_t v;

  initial begin
    tbl[0] = '{16'hFC0F, -1, '{1,0,6,6,10,4}, '{1,0,6,6,10,4}};
    tbl[1] = '{16'hFFFF, -1, '{0,1,0,0,15,0}, '{0,1,0,0,15,0}};
    tbl[2] = '{16'h0FFF, -1, '{1,0,13,4,15,2}, '{1,0,13,4,15,2}};
    tbl[3] = '{16'hFF1F, 8, '{0,1,0,3,8,0}, '{1,0,6,3,8,2}};
    tbl[4] = '{16'h0000, -1, '{1,0,7,16,15,8}, '{1,0,7,16,15,8}};
    tbl[5] = '{16'h0000, 0, '{0,1,0,0,0,0}, '{0,1,0,0,0,0}};
    tbl[6] = '{16'hFFF0, -1, '{1,0,1,4,4,3}, '{1,0,1,4,4,3}};
    tbl[7] = '{16'hFFFB, -1, '{0,1,0,1,3,0}, '{0,1,0,1,3,0}};

    #1;
    chk("reset outputs", outs_or(), 0);
    repeat (3) @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle outputs", outs_or(), 0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      logic [15:0] d;
      int s, len, o;
      d = 16'($urandom);
      s = $urandom_range(0, 15);
      len = $urandom_range(0, 7);
      for (int b = 0; b < 16; b++)
        if (b >= s && b < s + len) d[b] = 1'b0;
      o = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      v.dirty = d;
      v.oor = o;
      v.e4 = model(d, o, 4);
      v.e3 = model(d, o, 3);
      run(v, 1'b0, $sformatf("rnd%0d", i));
    end

    run(tbl[0], 1'b1, "restart-ignored");

    // Async reset in the middle of the sampling window at tap 5.
    begin
      bit hit;
      @(negedge clk);
      dirty_map = 16'hFC0F;
      oor_tap = -1;
      ups = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        #1;
        if (ups == 5) begin
          hit = 1'b1;
          break;
        end
      end
      chk("reach tap5", int'(hit), 1);
      repeat (4) @(negedge clk);
      #1 arst = 1'b1;
      #1 chk("async reset outputs", outs_or(), 0);
      repeat (2) @(negedge clk);
      chk("held reset outputs", outs_or(), 0);
      arst = 1'b0;
      loads = 0; ups = 0; downs = 0; ups3 = 0; downs3 = 0;
      repeat (6) @(negedge clk);
      chk("no move after reset", ups + downs + ups3 + downs3, 0);
      chk("no load after reset", loads, 0);
      chk("idle after reset", outs_or(), 0);
      run(tbl[0], 1'b0, "post-reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bclk_eye_trainer.md
BCLK_EYE_TRAINER -- requirements
Module: bclk_eye_trainer

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 8: idle cycles after each delay-line change before sampling (1..255).
REQ-002 SHALL provide parameter SAMPLES, default 16: eye-monitor observation cycles per tap (1..255).
REQ-003 SHALL provide parameter MAX_TAPS, default 128: number of taps swept (2..255).
REQ-004 SHALL provide parameter MIN_EYE, default 4: minimum clean taps for pass (1..MAX_TAPS).
REQ-005 SHALL have one clock, FAB_CLK; all logic on its rising edge.
REQ-006 FAB_CLK  in  1  fabric clock shared with the IOD RX_CLK.
REQ-007 ARST  in  1  asynchronous, active-high reset.
REQ-008 START  in  1  single-cycle request to begin training.
REQ-009 EYE_MONITOR_EARLY_0  in  1  sticky early flag from the IOD.
REQ-010 EYE_MONITOR_LATE_0  in  1  sticky late flag from the IOD.
REQ-011 DELAY_LINE_OUT_OF_RANGE_0  in  1  delay line at its limit.
REQ-012 DELAY_LINE_LOAD_0  out  1  one-cycle pulse reloading the preset delay (tap 0).
REQ-013 DELAY_LINE_MOVE_0  out  1  one-cycle pulse stepping one tap.
REQ-014 DELAY_LINE_DIRECTION_0  out  1  1 = increment, 0 = decrement; valid whenever MOVE is high.
REQ-015 EYE_MONITOR_CLEAR_FLAGS_0  out  1  one-cycle pulse clearing the sticky flags.
REQ-016 BUSY / DONE / FAIL  out  1 each  status; DONE and FAIL hold until the next accepted START.
REQ-017 CENTER_TAP  out  8  final tap position; EYE_WIDTH  out  8  clean-tap count.

Function
REQ-018 SHALL use states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, BACK, BSETTLE, DONE, FAIL.
REQ-019 IDLE/DONE/FAIL + START -> LOAD: BUSY=1, DONE=FAIL=0, tap counter=0, eye_start/eye_end invalid.
REQ-020 LOAD: LOAD pulse 1 cycle -> CLEAR; CLEAR: CLEAR_FLAGS pulse 1 cycle -> SETTLE (SETTLE_CYCLES cycles) -> SAMPLE (SAMPLES cycles) -> STEP.
REQ-021 SAMPLE SHALL OR EARLY|LATE over the window; tap "clean" iff the OR is 0.
REQ-022 STEP, clean tap: record eye_start on the first clean tap, update eye_end=tap.
REQ-023 STEP, dirty tap after a valid eye_start: sweep ends (first contiguous eye only).
REQ-024 STEP, sweep ends also when tap==MAX_TAPS-1 or OUT_OF_RANGE was high in the window; that tap itself is evaluated first, except when OUT_OF_RANGE, in which case it counts as dirty.
REQ-025 STEP, sweep continuing: MOVE=1, DIRECTION=1, tap+1 -> CLEAR; per-tap period = SETTLE_CYCLES+SAMPLES+2 cycles.
REQ-026 Sweep end: no eye_start or width=eye_end-eye_start+1 < MIN_EYE -> FAIL; otherwise center=(eye_start+eye_end)>>1 (floor), EYE_WIDTH=width, -> BACK.
REQ-027 BACK: while tap>center, MOVE=1, DIRECTION=0, tap-1, -> BSETTLE (SETTLE_CYCLES) -> BACK; tap==center -> DONE.
REQ-028 DONE: BUSY=0, DONE=1, CENTER_TAP=center. FAIL: BUSY=0, FAIL=1, CENTER_TAP=0, EYE_WIDTH = width if computed, else 0; delay line is left where it stopped.
REQ-029 START while BUSY SHALL be ignored.
REQ-030 MOVE, LOAD and CLEAR_FLAGS SHALL never be high in the same cycle.

Reset
REQ-031 ARST SHALL force IDLE immediately; every output is 0, including mid-pulse and mid-sweep; no pending move is issued after release.
REQ-032 After ARST release the first START SHALL run a full fresh training from LOAD.

Verification
REQ-033 SETTLE_CYCLES=2, SAMPLES=4, MAX_TAPS=16, MIN_EYE=4; flags at taps 0-3, 10-15 -> 10 up-moves, EYE_WIDTH=6, CENTER_TAP=6, 4 down-moves, DONE=1.
REQ-034 Same params, flags at every tap -> 15 up-moves, FAIL=1, CENTER_TAP=0, EYE_WIDTH=0, zero down-moves.
REQ-035 Clean taps 12-15 only -> EYE_WIDTH=4, CENTER_TAP=13, 2 down-moves, DONE=1.
REQ-036 Clean taps 5-7, OUT_OF_RANGE at tap 8 -> sweep stops at tap 8, width 3 < MIN_EYE -> FAIL=1; with MIN_EYE=3 -> CENTER_TAP=6, DONE=1.
REQ-037 ARST pulsed during SAMPLE at tap 5 -> all outputs 0 asynchronously; new START yields LOAD pulse and a full sweep from tap 0.
REQ-038 START re-asserted during the sweep -> no restart; tap sequence and result are identical to REQ-033.
